cw305_ext_bus_fe: RTL and testbench

Register front-end for the external target board. It consumes the SAM3U-style parallel bus forwarded to `ext_usb_*` and retimes it into `usb_clk`. It decodes single-cycle register write strobes and level read requests, and drives read data back onto the bus with a registered output enable. It sits directly downstream of the SAM3U bus feedthrough and upstream of the target's register file.

---
 rtl/cw305_ext_bus_fe_pkg.sv | 25 ++
 rtl/cw305_ext_bus_fe.sv | 101 ++++++++++
 tb/tb_cw305_ext_bus_fe.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cw305_ext_bus_fe_pkg.sv
// Shared bus constants for the CW305 register front-end and the target register file.
// Register-select width, default byte-index width and named register addresses.
package cw305_ext_bus_fe_pkg;

  localparam int BYTECNT_SIZE_DEF = 7;
  localparam int REG_SEL_W        = 4;

  localparam logic [REG_SEL_W-1:0] REG_CLKSETTINGS = 4'h0;
  localparam logic [REG_SEL_W-1:0] REG_USER_LED    = 4'h1;
  localparam logic [REG_SEL_W-1:0] REG_CRYPT_TYPE  = 4'h2;
  localparam logic [REG_SEL_W-1:0] REG_CRYPT_REV   = 4'h3;
  localparam logic [REG_SEL_W-1:0] REG_IDENTIFY    = 4'h4;
  localparam logic [REG_SEL_W-1:0] REG_CRYPT_GO    = 4'h5;
  localparam logic [REG_SEL_W-1:0] REG_CRYPT_TEXTIN  = 4'h6;
  localparam logic [REG_SEL_W-1:0] REG_CRYPT_CIPHERIN = 4'h7;
  localparam logic [REG_SEL_W-1:0] REG_CRYPT_TEXTOUT = 4'h8;
  localparam logic [REG_SEL_W-1:0] REG_CRYPT_CIPHEROUT = 4'h9;
  localparam logic [REG_SEL_W-1:0] REG_CRYPT_KEY   = 4'ha;
  localparam logic [REG_SEL_W-1:0] REG_BUILDTIME   = 4'hb;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cw305_ext_bus_fe.sv
// Retimes the host parallel bus into usb_clk; write strobe 2 edges, read data 2 edges after sample.
// No backpressure: the host paces transfers, protocol conflicts only set a sticky err_flag.
module cw305_ext_bus_fe
  import cw305_ext_bus_fe_pkg::*;
#(
  parameter int pBYTECNT_SIZE = BYTECNT_SIZE_DEF,
  parameter int pADDR_WIDTH   = pBYTECNT_SIZE + REG_SEL_W
) (
  input  logic                     usb_clk,
  input  logic                     resetn,
  input  logic [pADDR_WIDTH-1:0]   usb_addr,
  input  logic [7:0]               usb_din,
  input  logic                     usb_rdn,
  input  logic                     usb_wrn,
  input  logic                     usb_cen,
  output logic [7:0]               usb_dout,
  output logic                     usb_isout,
  output logic [REG_SEL_W-1:0]     reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic [7:0]               reg_datai,
  input  logic [7:0]               reg_datao,
  output logic                     reg_addrvalid,
  output logic                     reg_read,
  output logic                     reg_write,
  output logic                     err_flag,
  output logic [15:0]              write_count
);

  logic [pADDR_WIDTH-1:0] addr_s1;
  logic [7:0]             din_s1;
  logic                   rdn_s1;
  logic                   wrn_s1;
  logic                   cen_s1;
  logic                   wrn_s2;
  logic [15:0]            write_cnt_q;

  logic write_accept;
  logic read_cond;
  logic conflict;

  // wrn stages reset low so a wrn held low across reset release never looks like a falling edge.
  always_ff @(posedge usb_clk or negedge resetn) begin
    if (!resetn) begin
      addr_s1 <= '0;
      din_s1  <= '0;
      rdn_s1  <= 1'b1;
      cen_s1  <= 1'b1;
      wrn_s1  <= 1'b0;
      wrn_s2  <= 1'b0;
    end else begin
      addr_s1 <= usb_addr;
      din_s1  <= usb_din;
      rdn_s1  <= usb_rdn;
      cen_s1  <= usb_cen;
      wrn_s1  <= usb_wrn;
      wrn_s2  <= wrn_s1;
    end
  end

  assign write_accept = !wrn_s1 && wrn_s2 && !cen_s1 && rdn_s1;
  assign read_cond    = !rdn_s1 && !cen_s1 && wrn_s1;
  assign conflict     = !rdn_s1 && !wrn_s1 && !cen_s1;

  always_ff @(posedge usb_clk or negedge resetn) begin
    if (!resetn) begin
      reg_address   <= '0;
      reg_bytecnt   <= '0;
      reg_datai     <= '0;
      reg_addrvalid <= 1'b0;
      reg_read      <= 1'b0;
      reg_write     <= 1'b0;
      err_flag      <= 1'b0;
      write_cnt_q   <= '0;
      usb_dout      <= '0;
      usb_isout     <= 1'b0;
    end else begin
      reg_write     <= write_accept;
      reg_read      <= read_cond;
      reg_addrvalid <= !cen_s1;
      usb_isout     <= reg_read;
      // Reads reload the address every cycle so burst reads can walk the byte index.
      if (write_accept || read_cond) begin
        reg_address <= addr_s1[pADDR_WIDTH-1:pBYTECNT_SIZE];
        reg_bytecnt <= addr_s1[pBYTECNT_SIZE-1:0];
      end
      if (write_accept) begin
        reg_datai   <= din_s1;
        write_cnt_q <= sat_inc16(write_cnt_q);
      end
      if (reg_read) begin
        usb_dout <= reg_datao;
      end
      if (conflict) begin
        err_flag <= 1'b1;
      end
    end
  end

  assign write_count = write_cnt_q;

endmodule

// File: tb/tb_cw305_ext_bus_fe.sv
// Directed bench for cw305_ext_bus_fe: write strobe, burst read, conflict, reset-held wrn,
// counter saturation and asynchronous reset during a read.
module tb_cw305_ext_bus_fe;

  localparam int BW = 7;
  localparam int AW = BW + 4;

  logic          usb_clk;
  logic          resetn;
  logic [AW-1:0] usb_addr;
  logic [7:0]    usb_din;
  logic          usb_rdn;
  logic          usb_wrn;
  logic          usb_cen;
  logic [7:0]    usb_dout;
  logic          usb_isout;
  logic [3:0]    reg_address;
  logic [BW-1:0] reg_bytecnt;
  logic [7:0]    reg_datai;
  logic [7:0]    reg_datao;
  logic          reg_addrvalid;
  logic          reg_read;
  logic          reg_write;
  logic          err_flag;
  logic [15:0]   write_count;

  int n_checks = 0;
  int n_errors = 0;

  cw305_ext_bus_fe #(.pBYTECNT_SIZE(BW), .pADDR_WIDTH(AW)) dut (
    .usb_clk      (usb_clk),
    .resetn       (resetn),
    .usb_addr     (usb_addr),
    .usb_din      (usb_din),
    .usb_rdn      (usb_rdn),
    .usb_wrn      (usb_wrn),
    .usb_cen      (usb_cen),
    .usb_dout     (usb_dout),
    .usb_isout    (usb_isout),
    .reg_address  (reg_address),
    .reg_bytecnt  (reg_bytecnt),
    .reg_datai    (reg_datai),
    .reg_datao    (reg_datao),
    .reg_addrvalid(reg_addrvalid),
    .reg_read     (reg_read),
    .reg_write    (reg_write),
    .err_flag     (err_flag),
    .write_count  (write_count)
  );

  // Register file model: read data depends only on the byte index.
  assign reg_datao = {1'b0, reg_bytecnt} ^ 8'h3c;

  initial usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge usb_clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d);
    usb_addr = a;
    usb_din  = d;
    usb_cen  = 1'b0;
    usb_wrn  = 1'b0;
    cyc();
    usb_wrn  = 1'b1;
    usb_cen  = 1'b1;
    cyc();
  endtask

  logic [5:0]  wr_seen;
  logic [6:0]  rd_seen;
  logic [6:0]  iso_seen;
  logic [7:0]  dout_seen [7];
  logic [7:0]  exp_dout  [7];
  logic [15:0] exp_cnt   [5];
  int          pulses;

  initial begin
    exp_dout = '{8'h00, 8'h00, 8'h3c, 8'h3d, 8'h3e, 8'h3e, 8'h3e};
    exp_cnt  = '{16'hfffd, 16'hfffe, 16'hffff, 16'hffff, 16'hffff};

    resetn   = 1'b0;
    usb_addr = '0;
    usb_din  = '0;
    usb_rdn  = 1'b1;
    usb_wrn  = 1'b1;
    usb_cen  = 1'b1;
    #2;
    check("rst_isout", usb_isout, 1'b0);
    check("rst_dout", usb_dout, 8'h00);
    check("rst_write_count", write_count, 16'h0);
    cyc();
    cyc();
    resetn = 1'b1;

    // Idle bus
    repeat (10) cyc();
    check("idle_outputs", {reg_write, reg_read, reg_addrvalid, err_flag, usb_isout}, 5'b0);
    check("idle_regs", {reg_address, reg_bytecnt, reg_datai}, '0);

    // Single write, wrn held low for 4 samples
    usb_addr = 11'h285;
    usb_din  = 8'ha5;
    usb_cen  = 1'b0;
    usb_wrn  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      wr_seen[i] = reg_write;
      if (i == 1) check("wr_addrvalid", reg_addrvalid, 1'b1);
      if (i == 3) begin
        usb_wrn = 1'b1;
        usb_cen = 1'b1;
      end
    end
    check("wr_strobe_pattern", wr_seen, 6'b000010);
    check("wr_address", reg_address, 4'h5);
    check("wr_bytecnt", reg_bytecnt, 7'h05);
    check("wr_datai", reg_datai, 8'ha5);
    check("wr_count", write_count, 16'd1);
    check("wr_addrvalid_off", reg_addrvalid, 1'b0);
    cyc();
    cyc();

    // Burst read 0x100 -> 0x101 -> 0x102
    usb_cen  = 1'b0;
    usb_rdn  = 1'b0;
    usb_addr = 11'h100;
    for (int i = 0; i < 7; i++) begin
      cyc();
      rd_seen[i]   = reg_read;
      iso_seen[i]  = usb_isout;
      dout_seen[i] = usb_dout;
      case (i)
        0: usb_addr = 11'h101;
        1: usb_addr = 11'h102;
        2: begin
          usb_rdn = 1'b1;
          usb_cen = 1'b1;
        end
        default: ;
      endcase
    end
    check("rd_read_pattern", rd_seen, 7'b0001110);
    check("rd_isout_pattern", iso_seen, 7'b0011100);
    for (int i = 0; i < 7; i++) check($sformatf("rd_dout[%0d]", i), dout_seen[i], exp_dout[i]);
    check("rd_last_addr", {reg_address, reg_bytecnt}, {4'h2, 7'h02});
    check("rd_no_write", write_count, 16'd1);
    cyc();
    cyc();

    // Read/write conflict
    check("err_before", err_flag, 1'b0);
    usb_rdn = 1'b0;
    usb_wrn = 1'b0;
    usb_cen = 1'b0;
    cyc();
    usb_rdn = 1'b1;
    usb_wrn = 1'b1;
    usb_cen = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      pulses += int'(reg_write) + int'(reg_read);
      if (i == 0) check("err_set", err_flag, 1'b1);
    end
    check("err_no_strobes", pulses, 0);
    repeat (5) cyc();
    check("err_sticky", err_flag, 1'b1);
    check("err_count", write_count, 16'd1);

    // wrn held low through reset: no write until it is seen high
    resetn   = 1'b0;
    usb_wrn  = 1'b0;
    usb_cen  = 1'b0;
    usb_rdn  = 1'b1;
    usb_addr = 11'h300;
    usb_din  = 8'h5a;
    #1;
    check("rst2_err_clear", err_flag, 1'b0);
    check("rst2_count_clear", write_count, 16'd0);
    cyc();
    cyc();
    resetn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      pulses += int'(reg_write);
    end
    check("rst2_no_strobe", pulses, 0);
    usb_wrn = 1'b1;
    cyc();
    usb_wrn = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      pulses += int'(reg_write);
    end
    check("rst2_one_strobe", pulses, 1);
    usb_wrn = 1'b1;
    usb_cen = 1'b1;
    cyc();
    check("rst2_count", write_count, 16'd1);
    check("rst2_datai", reg_datai, 8'h5a);
    check("rst2_addr", {reg_address, reg_bytecnt}, {4'h6, 7'h00});

    // Saturation: preload the counter near the top to keep run time short
    force dut.write_cnt_q = 16'hfffc;
    #1;
    release dut.write_cnt_q;
    for (int i = 0; i < 5; i++) begin
      do_write(AW'(11'h080 + i), 8'(8'h10 + i));
      check($sformatf("sat_count[%0d]", i), write_count, exp_cnt[i]);
    end
    check("sat_datai", reg_datai, 8'h14);
    cyc();
    cyc();

    // Asynchronous reset during an active read
    usb_cen  = 1'b0;
    usb_rdn  = 1'b0;
    usb_addr = 11'h105;
    repeat (3) cyc();
    check("rdrst_isout_on", usb_isout, 1'b1);
    check("rdrst_dout", usb_dout, 8'h39);
    #2;
    resetn = 1'b0;
    #1;
    check("rdrst_isout_off", usb_isout, 1'b0);
    check("rdrst_read_off", reg_read, 1'b0);
    check("rdrst_dout_clear", usb_dout, 8'h00);
    check("rdrst_addrvalid", reg_addrvalid, 1'b0);
    usb_cen = 1'b1;
    usb_rdn = 1'b1;
    cyc();
    resetn = 1'b1;
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
